add16_nibble_sched: RTL and testbench

Two-requester scheduler that shares one 4-bit ripple adder (`fa4_mbit`) to perform wide additions nibble by nibble. Each requester presents full-width operands and a carry-in. A round-robin arbiter grants one request at a time. A sequencer then drives the shared 4-bit adder over NIB cycles, chaining the carry, and returns the registered sum with a one-cycle done pulse.

---
 rtl/add16_nibble_sched_pkg.sv | 23 ++
 rtl/add16_nibble_sched_fa4.sv | 26 ++
 rtl/add16_nibble_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_add16_nibble_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add16_nibble_sched_pkg.sv
// Shared definitions for the nibble-serial adder scheduler: FSM encoding,
// nibble width, default operand size and a small width helper.
package add16_nibble_sched_pkg;

  // Width of one slice of the shared adder.
  localparam int NIB_BITS = 4;

  // Default number of nibbles per operand (16-bit operands).
  localparam int NIB_DEFAULT = 4;

  // Sequencer states. Encoding 2'd3 is unused and falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the nibble index: clog2(nib), but never narrower than one bit.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/add16_nibble_sched_fa4.sv
// Shared 4-bit ripple-carry adder slice. Purely combinational; the
// scheduler feeds it one operand nibble per cycle and chains the carry.
module fa4_mbit
  import add16_nibble_sched_pkg::*;
(
  input  logic [NIB_BITS-1:0] i_a,
  input  logic [NIB_BITS-1:0] i_b,
  input  logic                i_ci,
  output logic [NIB_BITS-1:0] o_s,
  output logic                o_co
);

  // Carry chain: w_c[0] is the incoming carry, w_c[NIB_BITS] leaves the slice.
  logic [NIB_BITS:0] w_c;

  assign w_c[0] = i_ci;

  // One full adder per bit, rippling the carry upward.
  for (genvar g = 0; g < NIB_BITS; g++) begin : g_fa
    assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_co = w_c[NIB_BITS];

endmodule

// File: rtl/add16_nibble_sched.sv
// Two-requester scheduler that time-shares one 4-bit adder to perform
// W-bit additions one nibble per cycle, with round-robin arbitration.
//
// Handshake: reqN is a level sampled only while IDLE. gntN is a one-cycle
// pulse meaning "your operands were captured this edge"; the requester must
// drop reqN after seeing gntN or it is served again on the next IDLE.
// done is a one-cycle pulse; sum/co/id stay valid until the next done.
// Requests seen outside IDLE are ignored, never queued.
module add16_nibble_sched
  import add16_nibble_sched_pkg::*;
#(
  parameter  int NIB = NIB_DEFAULT,
  localparam int W   = NIB_BITS * NIB
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req0,
  input  logic [W-1:0] i_a0,
  input  logic [W-1:0] i_b0,
  input  logic         i_ci0,
  input  logic         i_req1,
  input  logic [W-1:0] i_a1,
  input  logic [W-1:0] i_b1,
  input  logic         i_ci1,
  output logic         o_gnt0,
  output logic         o_gnt1,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_id,
  output logic [W-1:0] o_sum,
  output logic         o_co,
  output state_t       o_state
);

  localparam int IDXW = idx_width(NIB);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            r_last_id;
  logic            r_gid;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_work;

  // Registered outputs and their next values.
  logic            r_gnt0;
  logic            r_gnt1;
  logic            r_busy;
  logic            r_done;
  logic            r_id;
  logic [W-1:0]    r_sum;
  logic            r_co;
  logic            w_gnt0_d;
  logic            w_gnt1_d;
  logic            w_busy_d;
  logic            w_done_d;
  logic            w_id_d;
  logic [W-1:0]    w_sum_d;
  logic            w_co_d;

  // Arbiter and adder wiring.
  logic                w_req_any;
  logic                w_grant_id;
  logic                w_take;
  logic                w_last_nib;
  logic [NIB_BITS-1:0] w_a_nib;
  logic [NIB_BITS-1:0] w_b_nib;
  logic [NIB_BITS-1:0] w_add_s;
  logic                w_add_co;
  logic [W-1:0]        w_work_final;

  // Round-robin pick: a lone request wins outright; on a tie the requester
  // that did not win last time is granted.
  always_comb begin
    w_req_any  = i_req0 | i_req1;
    w_grant_id = (i_req0 & i_req1) ? ~r_last_id : i_req1;
    w_take     = (r_state == ST_IDLE) && w_req_any;
    w_last_nib = (r_idx == LAST_IDX);
  end

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_nib = r_a[i*NIB_BITS +: NIB_BITS];
        w_b_nib = r_b[i*NIB_BITS +: NIB_BITS];
      end
    end
  end

  // The single shared adder slice.
  fa4_mbit u_fa4 (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .i_ci (r_carry),
    .o_s  (w_add_s),
    .o_co (w_add_co)
  );

  // Work register with the current nibble replaced by this cycle's sum;
  // on the last nibble this is the complete result.
  always_comb begin
    w_work_final = r_work;
    for (int i = 0; i < NIB; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_work_final[i*NIB_BITS +: NIB_BITS] = w_add_s;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // Hold the sequencer state; reset abandons any in-flight operation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = w_req_any ? ST_RUN : ST_IDLE;
      ST_RUN:  w_state_nxt = w_last_nib ? ST_DONE : ST_RUN;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: next values of the registered outputs.
  always_comb begin
    w_gnt0_d = w_take & ~w_grant_id;
    w_gnt1_d = w_take &  w_grant_id;
    w_busy_d = (w_state_nxt != ST_IDLE);
    w_done_d = (r_state == ST_RUN) && w_last_nib;
    w_sum_d  = r_sum;
    w_co_d   = r_co;
    w_id_d   = r_id;
    if (w_done_d) begin
      w_sum_d = w_work_final;
      w_co_d  = w_add_co;
      w_id_d  = r_gid;
    end
  end

  // Register the outputs so every port is driven straight from a flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_id   <= 1'b0;
      r_sum  <= '0;
      r_co   <= 1'b0;
    end else begin
      r_gnt0 <= w_gnt0_d;
      r_gnt1 <= w_gnt1_d;
      r_busy <= w_busy_d;
      r_done <= w_done_d;
      r_id   <= w_id_d;
      r_sum  <= w_sum_d;
      r_co   <= w_co_d;
    end
  end

  // Remember the last winner so ties alternate; starts at 1 so that
  // requester 0 wins the first tie after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_id <= 1'b1;
    end else if (w_take) begin
      r_last_id <= w_grant_id;
    end
  end

  // Capture operands on a grant, then walk the nibbles chaining the carry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_gid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_a     <= w_grant_id ? i_a1 : i_a0;
            r_b     <= w_grant_id ? i_b1 : i_b0;
            r_work  <= w_grant_id ? i_a1 : i_a0;
            r_carry <= w_grant_id ? i_ci1 : i_ci0;
            r_idx   <= '0;
            r_gid   <= w_grant_id;
          end
        end
        ST_RUN: begin
          r_work  <= w_work_final;
          r_carry <= w_add_co;
          // Explicit wrap keeps the index in range for any NIB.
          r_idx   <= w_last_nib ? '0 : r_idx + 1'b1;
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  assign o_gnt0  = r_gnt0;
  assign o_gnt1  = r_gnt1;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_id    = r_id;
  assign o_sum   = r_sum;
  assign o_co    = r_co;
  assign o_state = r_state;

endmodule

// File: tb/tb_add16_nibble_sched.sv
// Testbench for add16_nibble_sched: directed and random requests, a
// cycle-level reference model of the arbitration/latency rules and an
// arithmetic reference for the sum, checked by an independent monitor.
module tb_add16_nibble_sched;
  import add16_nibble_sched_pkg::*;

  localparam int NIB = 4;
  localparam int W   = 16;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ci0 = 1'b0, ci1 = 1'b0;
  logic         gnt0, gnt1, busy, done, id, co;
  logic [W-1:0] sum;
  state_t       state_dbg;

  always #5 clk = ~clk;

  add16_nibble_sched #(.NIB(NIB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_a0(a0), .i_b0(b0), .i_ci0(ci0),
    .i_req1(req1), .i_a1(a1), .i_b1(b1), .i_ci1(ci1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_busy(busy), .o_done(done),
    .o_id(id), .o_sum(sum), .o_co(co), .o_state(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_co_q[$];
  logic         exp_id_q[$];
  int           exp_cyc_q[$];
  logic         gnt_id_q[$];
  int           gnt_cyc_q[$];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  // A grant is possible once NIB+2 edges have passed since the previous one;
  // ties go to the requester that did not win last; sum is plain a+b+ci.
  logic         m_last_id = 1'b1;
  int           m_last_grant = -1000;
  logic         m_g;
  logic [W:0]   m_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete(); exp_co_q.delete(); exp_id_q.delete(); exp_cyc_q.delete();
      gnt_id_q.delete(); gnt_cyc_q.delete();
      m_last_id    = 1'b1;
      m_last_grant = -1000;
    end else begin
      cyc++;
      if ((cyc >= m_last_grant + NIB + 2) && (req0 || req1)) begin
        m_g = (req0 && req1) ? !m_last_id : req1;
        m_last_id    = m_g;
        m_last_grant = cyc;
        m_full = m_g ? ({1'b0, a1} + {1'b0, b1} + {{W{1'b0}}, ci1})
                     : ({1'b0, a0} + {1'b0, b0} + {{W{1'b0}}, ci0});
        gnt_id_q.push_back(m_g);
        gnt_cyc_q.push_back(cyc);
        exp_q.push_back(m_full[W-1:0]);
        exp_co_q.push_back(m_full[W]);
        exp_id_q.push_back(m_g);
        exp_cyc_q.push_back(cyc + NIB);
      end
    end
  end

  // ---------------- monitor ----------------
  logic         p_id;
  int           p_cyc;
  logic [W-1:0] p_sum;
  logic         p_co;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_gnt", {gnt1, gnt0}, 0);
      chk("rst_sum", sum, 0);
      chk("rst_co_id", {co, id}, 0);
      chk("rst_state", state_dbg, ST_IDLE);
    end else begin
      chk("busy", busy, (cyc >= m_last_grant) && (cyc <= m_last_grant + NIB));
      if (gnt0 && gnt1) chk("gnt_both", 2'b11, 2'b01);
      if (gnt0 || gnt1) begin
        if (gnt_id_q.size() == 0) begin
          chk("gnt_unexpected", {gnt1, gnt0}, 0);
        end else begin
          p_id  = gnt_id_q.pop_front();
          p_cyc = gnt_cyc_q.pop_front();
          chk("gnt_id", gnt1, p_id);
          chk("gnt_cycle", cyc, p_cyc);
        end
      end else if (gnt_cyc_q.size() != 0 && gnt_cyc_q[0] <= cyc) begin
        p_cyc = gnt_cyc_q.pop_front();
        p_id  = gnt_id_q.pop_front();
        chk("gnt_missing", 0, 1);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          p_sum = exp_q.pop_front();
          p_co  = exp_co_q.pop_front();
          p_id  = exp_id_q.pop_front();
          p_cyc = exp_cyc_q.pop_front();
          chk("sum", sum, p_sum);
          chk("co", co, p_co);
          chk("id", id, p_id);
          chk("done_cycle", cyc, p_cyc);
        end
      end else if (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
        p_sum = exp_q.pop_front();
        p_co  = exp_co_q.pop_front();
        p_id  = exp_id_q.pop_front();
        p_cyc = exp_cyc_q.pop_front();
        chk("done_missing", 0, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Raise a request, wait (bounded) for its grant, then drop it.
  task automatic do_req(input bit which, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci);
    bit seen;
    @(posedge clk); #2;
    if (which) begin a1 = a; b1 = b; ci1 = ci; req1 = 1'b1; end
    else       begin a0 = a; b0 = b; ci0 = ci; req0 = 1'b1; end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (which ? gnt1 : gnt0) seen = 1'b1;
    end
    if (!seen) chk("gnt_timeout", 0, 1);
    @(posedge clk); #2;
    if (which) req1 = 1'b0; else req0 = 1'b0;
  endtask

  // Wait until every expected event has been seen and the DUT is idle.
  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0) && (gnt_id_q.size() == 0) && !req0 && !req1 &&
             (cyc > m_last_grant + NIB);
    end
    if (!idle) chk("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic rand_stream(input bit which, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 7)) @(posedge clk);
      do_req(which, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_sum", sum, 0);
    chk("reset_flags", {busy, done, id, co, gnt0, gnt1}, 0);
    chk("reset_state", state_dbg, ST_IDLE);

    // Directed single operations.
    do_req(0, 16'h1234, 16'h4321, 1'b0); drain();
    do_req(1, 16'hFFFF, 16'h0001, 1'b0); drain();
    do_req(0, 16'h7FFF, 16'h8000, 1'b1); drain();
    do_req(1, 16'hFFFF, 16'hFFFF, 1'b1); drain();

    // Contention from reset, then repeated ties.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      fork
        do_req(0, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        do_req(1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      join
      drain();
    end

    // Request while busy: req1 raised during RUN waits for the next IDLE.
    fork
      do_req(0, 16'hABCD, 16'h1111, 1'b0);
      begin
        for (int i = 0; i < 100 && !gnt0; i++) @(negedge clk);
        @(posedge clk);
        do_req(1, 16'h0F0F, 16'hF0F1, 1'b1);
      end
    join
    drain();

    // Reset in the middle of RUN abandons the operation.
    do_req(0, 16'h5A5A, 16'hA5A5, 1'b1);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_out", {done, id, co, sum}, 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    do_req(0, 16'h0001, 16'h0001, 1'b0); drain();
    chk("post_rst_sum", sum, 16'h0002);

    // Random traffic from both requesters.
    fork
      rand_stream(0, 12);
      rand_stream(1, 12);
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
